// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the sequential divider.
//   div_state_e       : FSM encoding (IDLE / CALC / DONE)
//   DIV_WIDTH_DEFAULT : default operand width
//   DIV_MAX_W         : width of the abs_mag working type; WIDTH must be below it
//   abs_mag()         : magnitude of an already sign/zero-extended operand
package div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEFAULT = 32;
   localparam int DIV_MAX_W         = 128;

   // The caller sign-extends (signed mode) or zero-extends the operand to
   // DIV_MAX_W bits, so the most negative WIDTH-bit value negates cleanly into
   // its unsigned magnitude before the caller truncates back to WIDTH.
   function automatic logic [DIV_MAX_W-1:0] abs_mag(input logic [DIV_MAX_W-1:0] value,
                                                    input logic                 signed_en);
      abs_mag = (signed_en && value[DIV_MAX_W-1]) ? -value : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem_i     : partial remainder (WIDTH)
//   quo_i     : dividend bits still to shift in / quotient bits so far (WIDTH)
//   divisor_i : divisor magnitude (WIDTH)
//   rem_o     : partial remainder after this step
//   quo_o     : quotient register after this step (new bit in LSB)
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < divisor before the shift, so |shifted - divisor| < 2^WIDTH and the
   // WIDTH+1-bit difference's MSB is a reliable borrow/sign flag.
   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor_i};

   assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle integer divide sequencer for the EX stage.
//   clk, reset    : clock, async active-high reset
//   start, cancel : request strobe; flush (wins over everything)
//   op_signed     : two's-complement divide when 1
//   op_rem        : return remainder when 1, quotient when 0
//   src1, src2    : dividend, divisor
//   ack           : consumer took the result
//   busy          : iterating (CALC)
//   complete      : result valid, held until ack (DONE)
//   result        : selected, sign-corrected result; 0 while not complete
import div_pkg::*;

module div_seq #(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cancel,
   input  logic             op_signed,
   input  logic             op_rem,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             ack,
   output logic             busy,
   output logic             complete,
   output logic [WIDTH-1:0] result
);

   localparam int          CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic             op_rem_q, op_rem_d;

   logic [WIDTH-1:0] s1_mag, s2_mag;
   logic [WIDTH-1:0] step_rem, step_quo;
   logic [WIDTH-1:0] rem_fix, quo_fix;
   logic             accept;

   assign s1_mag = WIDTH'(abs_mag({{(DIV_MAX_W-WIDTH){op_signed & src1[WIDTH-1]}}, src1}, op_signed));
   assign s2_mag = WIDTH'(abs_mag({{(DIV_MAX_W-WIDTH){op_signed & src2[WIDTH-1]}}, src2}, op_signed));

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         op_rem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
         op_rem_q <= op_rem_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;
      op_rem_d = op_rem_q;
      busy     = 1'b0;
      complete = 1'b0;
      accept   = 1'b0;

      case (state_q)
         DIV_IDLE: accept = start;
         DIV_CALC: begin
            busy  = 1'b1;
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            complete = 1'b1;
            if (ack) begin
               if (start) accept  = 1'b1;
               else       state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase

      if (accept && !cancel) begin
         op_rem_d = op_rem;
         cnt_d    = '0;
         dvs_d    = s2_mag;
         if (src2 == '0) begin
            // Divide by zero: raw all-ones quotient and raw dividend, no fix-up.
            rem_d   = src1;
            quo_d   = '1;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = DIV_DONE;
         end else begin
            // Dividend magnitude sits in quo and shifts into rem bit by bit.
            rem_d   = '0;
            quo_d   = s1_mag;
            qsign_d = op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
            rsign_d = op_signed & src1[WIDTH-1];
            state_d = DIV_CALC;
         end
      end

      if (cancel) state_d = DIV_IDLE;
   end

   assign rem_fix = rsign_q ? -rem_q : rem_q;
   assign quo_fix = qsign_q ? -quo_q : quo_q;
   assign result  = complete ? (op_rem_q ? rem_fix : quo_fix) : '0;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, cancel = 1'b0, op_signed = 1'b0, op_rem = 1'b0, ack = 1'b0;
   logic [31:0] src1 = '0, src2 = '0;
   logic        busy, complete;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      int          start_cyc;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];

   div_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cancel    (cancel),
      .op_signed (op_signed),
      .op_rem    (op_rem),
      .src1      (src1),
      .src2      (src2),
      .ack       (ack),
      .busy      (busy),
      .complete  (complete),
      .result    (result)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // Monitor: on every rising edge of complete, pop the scoreboard and
   // compare both the result and the edges elapsed since the start edge.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (complete && !prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_complete result=%h", result);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_res"}, result, e.res);
               chk({e.name, "_lat"}, 32'(cyc - e.start_cyc), 32'(e.lat));
            end
         end
         prev = complete;
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic rm,
                        input logic [31:0] exp, input int lat, input string nm,
                        input bit push, input bit with_ack);
      @(negedge clk);
      src1 = a; src2 = b; op_signed = sg; op_rem = rm; start = 1'b1; ack = with_ack;
      if (push) sb.push_back('{exp, cyc, lat, nm});
      @(negedge clk);
      start = 1'b0; ack = 1'b0;
   endtask

   task automatic wait_done(input int exp_busy, input string nm);
      int bc = 0;
      int n  = 0;
      while (!complete && n < 100) begin
         if (busy) bc++;
         @(negedge clk);
         n++;
      end
      if (!complete) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout got=incomplete exp=complete", nm);
      end
      chk({nm, "_busy"}, 32'(bc), 32'(exp_busy));
   endtask

   task automatic release_res(input string nm);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({nm, "_released"}, {31'd0, complete}, 32'd0);
   endtask

   task automatic full(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic rm,
                       input logic [31:0] exp, input string nm);
      bit dz;
      dz = (b == 32'd0);
      issue(a, b, sg, rm, exp, dz ? 1 : 33, nm, 1'b1, 1'b0);
      wait_done(dz ? 0 : 32, nm);
      release_res(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_complete", {31'd0, complete}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      full(32'd7, 32'd2, 1'b0, 1'b0, 32'h00000003, "u7d2_q");
      full(32'd7, 32'd2, 1'b0, 1'b1, 32'h00000001, "u7d2_r");
      full(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD, "sm7d2_q");
      full(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, "sm7d2_r");
      full(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, "s7dm2_q");
      full(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, "s7dm2_r");
      full(32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, "dz_q");
      full(32'h12345678, 32'd0, 1'b0, 1'b1, 32'h12345678, "dz_r");
      full(32'h80000001, 32'd0, 1'b1, 1'b1, 32'h80000001, "dz_sr");
      full(32'hFFFFFFF9, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, "dz_sq");
      full(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, "ovf_q");
      full(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, "ovf_r");
      full(32'hFFFFFFFF, 32'h00010000, 1'b0, 1'b0, 32'h0000FFFF, "umax_q");

      // Hold DONE without ack, then chain a new divide with ack & start.
      issue(32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 33, "hold", 1'b1, 1'b0);
      wait_done(32, "hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_complete", {31'd0, complete}, 32'd1);
         chk("hold_result", result, 32'd100);
      end
      issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 33, "b2b", 1'b1, 1'b1);
      wait_done(32, "b2b");
      release_res("b2b");

      // cancel with a simultaneous start from IDLE must not launch anything.
      @(negedge clk);
      src1 = 32'd9; src2 = 32'd3; start = 1'b1; cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("cancel_start_busy", {31'd0, busy}, 32'd0);
      chk("cancel_start_complete", {31'd0, complete}, 32'd0);

      // cancel mid-CALC at T+10.
      issue(32'd7, 32'd2, 1'b0, 1'b0, 32'd0, 0, "cancel", 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", {31'd0, busy}, 32'd0);
      chk("cancel_complete", {31'd0, complete}, 32'd0);
      repeat (40) @(negedge clk);
      chk("cancel_never_done", {31'd0, complete}, 32'd0);

      // Async reset mid-CALC at T+20, off the clock edge.
      issue(32'd7, 32'd2, 1'b0, 1'b0, 32'd0, 0, "rst_mid", 1'b0, 1'b0);
      repeat (19) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_complete", {31'd0, complete}, 32'd0);
      chk("rstmid_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      full(32'd7, 32'd2, 1'b0, 1'b0, 32'h00000003, "post_rst_q");

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle integer divide sequencer for the execute stage. It accepts one division request from the EX stage, runs a radix-2 restoring division over WIDTH cycles, and holds the quotient or remainder with a level `complete` flag until the stage consumes it. Its `complete` output feeds the EX stage's ready-go term, so a divide instruction stalls the pipeline exactly as long as the divider is busy.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Must be a power of two and at least 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only in IDLE or DONE.
- cancel  in  1  flush from exception or branch; aborts any operation.
- op_signed  in  1  1 = two's-complement divide, 0 = unsigned divide.
- op_rem  in  1  1 = return the remainder, 0 = return the quotient.
- src1  in  WIDTH  dividend.
- src2  in  WIDTH  divisor.
- ack  in  1  consumer accepted the result (EX valid & MEM allowin).
- busy  out  1  high in CALC.
- complete  out  1  high in DONE.
- result  out  WIDTH  selected result; valid while complete = 1.

## Operation
- States are IDLE, CALC and DONE.
- IDLE: if start & ~cancel, latch op_signed, op_rem and the operand magnitudes. In signed mode the magnitude is the absolute value, with -2^(WIDTH-1) kept as the unsigned 2^(WIDTH-1).
  - Latch quotient sign = sign(src1) XOR sign(src2) and remainder sign = sign(src1), both forced to 0 in unsigned mode.
  - Clear the partial remainder and the iteration counter.
  - If src2 == 0, go directly to DONE; otherwise go to CALC.
- CALC: each cycle performs one restoring step.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem, using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep the difference and set quo[0] = 1.
  - The counter has $clog2(WIDTH) bits. When the counter reaches WIDTH-1, go to DONE after that step.
- DONE: result = op_rem ? signed-fixed remainder : signed-fixed quotient. "Signed-fixed" means two's-complement negated when the latched sign is 1.
  - ack & start: accept the new request as in IDLE. This supports back-to-back divides.
  - ack & ~start: go to IDLE.
  - No ack: hold DONE; result and complete stay stable.
- Divide by zero: quotient = all ones, remainder = src1 unchanged, with no sign fix-up. This applies in both modes.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = 0x80000000, remainder = 0. This falls out of the magnitude datapath; no special case is needed.
- cancel has priority over every other input. In any state it moves to IDLE on the next edge with complete = 0, and a start in the same cycle is ignored.
- start in CALC is ignored; the EX stage never issues it there.

## Timing
- Reset values: state = IDLE, busy = 0, complete = 0, result = 0, and all internal registers 0. Reset is effective immediately, including mid-CALC.
- Latency, with start accepted at edge T:
  - busy high from T+1 through T+WIDTH.
  - complete high from T+WIDTH+1.
  - For WIDTH = 32, complete rises 33 cycles after the start edge.
- Divide by zero: complete is high from T+1, and busy never rises.
- complete is a level, not a pulse; it falls on the edge after ack unless a simultaneous start (divide by zero) re-enters DONE.
- result is registered or derived from registers only, so it has no combinational path from the inputs.
- Throughput: one divide per WIDTH+1 cycles with back-to-back start & ack in DONE.

## Structure
- Package div_pkg holds:
  - state enum DIV_IDLE / DIV_CALC / DIV_DONE;
  - DIV_WIDTH_DEFAULT = 32;
  - the helper function abs_mag(value, signed_en).
- One sub-module, div_step: the combinational single restoring iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo. Keeping it separate lets it be unit-tested in isolation.
- The top module contains the FSM, counter, operand and sign latches, and result fix-up.

## Test plan
- Unsigned 7/2, op_rem = 0 then 1: complete at T+33 with result 0x00000003, then 0x00000001; busy high for 32 cycles.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x12345678 / 0: complete at T+1; quotient 0xFFFFFFFF, remainder 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0x00000000 at T+33.
- Hold ack = 0 for 5 cycles in DONE: complete and result stay stable. ack & start with 100/7: the next complete arrives 33 cycles later with quotient 14.
- cancel at T+10: IDLE at T+11, complete never rises. Async reset pulse at T+20: outputs go to 0 immediately, and a fresh start behaves nominally afterward.
